// File: rtl/mpe_fetch_ctrl.sv
// Fetch sequencer for matrix_pe: takes beat-count uops, streams NRAM/WRAM reads
// at sequential addresses and hands the returned beats to the PE on two buffered streams.

// Two-entry buffer for one read-data stream; head is held while not popped.
module mpe_fetch_fifo #(
    parameter int W = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign valid = (count != 2'd0);
    assign head  = mem[rd_ptr];
endmodule

// state | meaning
// IDLE  | waiting for a uop from the instruction buffer
// RUN   | forwarding the uop, issuing reads and draining beats to the PE
module mpe_fetch_ctrl #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 16,
    parameter int UOP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [UOP_W-1:0]  ib_ctl_uop,
    input  logic              ib_ctl_uop_valid,
    output logic              ib_ctl_uop_ready,
    output logic              nram_rd_en,
    output logic [ADDR_W-1:0] nram_rd_addr,
    input  logic [DATA_W-1:0] nram_rd_data,
    output logic              wram_rd_en,
    output logic [ADDR_W-1:0] wram_rd_addr,
    input  logic [DATA_W-1:0] wram_rd_data,
    output logic [UOP_W-1:0]  mpe_uop,
    output logic              mpe_uop_valid,
    input  logic              mpe_uop_ready,
    output logic [DATA_W-1:0] mpe_neuron,
    output logic              mpe_neuron_valid,
    input  logic              mpe_neuron_ready,
    output logic [DATA_W-1:0] mpe_weight,
    output logic              mpe_weight_valid,
    input  logic              mpe_weight_ready,
    output logic              busy,
    output logic              uop_done,
    output logic              err_zero_uop
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [UOP_W-1:0]  uop_q;
    logic [UOP_W-1:0]  nrem;
    logic [UOP_W-1:0]  wrem;
    logic              uop_sent;
    logic [ADDR_W-1:0] naddr;
    logic [ADDR_W-1:0] waddr;
    logic              n_inflight;
    logic              w_inflight;

    logic              uop_accept;
    logic              uop_handoff;
    logic              n_pop;
    logic              w_pop;
    logic              n_issue;
    logic              w_issue;
    logic [1:0]        n_count;
    logic [1:0]        w_count;
    logic [2:0]        n_level;
    logic [2:0]        w_level;
    logic              done_cond;

    mpe_fetch_fifo #(.W(DATA_W)) u_neuron_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (n_inflight),
        .push_data (nram_rd_data),
        .pop       (n_pop),
        .valid     (mpe_neuron_valid),
        .head      (mpe_neuron),
        .count     (n_count)
    );

    mpe_fetch_fifo #(.W(DATA_W)) u_weight_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_inflight),
        .push_data (wram_rd_data),
        .pop       (w_pop),
        .valid     (mpe_weight_valid),
        .head      (mpe_weight),
        .count     (w_count)
    );

    assign n_pop = mpe_neuron_valid & mpe_neuron_ready;
    assign w_pop = mpe_weight_valid & mpe_weight_ready;

    // Credit a same-cycle pop so an always-ready PE sees one beat per cycle.
    assign n_level = {1'b0, n_count} + {2'b00, n_inflight} - {2'b00, n_pop};
    assign w_level = {1'b0, w_count} + {2'b00, w_inflight} - {2'b00, w_pop};

    assign n_issue = (state == RUN) && (nrem != '0) && (n_level < 3'd2);
    assign w_issue = (state == RUN) && (wrem != '0) && (w_level < 3'd2);

    assign nram_rd_en   = n_issue;
    assign nram_rd_addr = naddr;
    assign wram_rd_en   = w_issue;
    assign wram_rd_addr = waddr;

    assign mpe_uop       = uop_q;
    assign mpe_uop_valid = (state == RUN) && !uop_sent;
    assign uop_handoff   = mpe_uop_valid && mpe_uop_ready;
    assign busy          = (state == RUN);
    assign uop_accept    = ib_ctl_uop_valid && ib_ctl_uop_ready;

    assign done_cond = uop_sent && (nrem == '0) && (wrem == '0) &&
                       (n_count == 2'd0) && (w_count == 2'd0) &&
                       !n_inflight && !w_inflight;

    always_comb begin
        state_nxt        = state;
        ib_ctl_uop_ready = 1'b0;
        uop_done         = 1'b0;
        case (state)
            IDLE: begin
                ib_ctl_uop_ready = 1'b1;
                if (ib_ctl_uop_valid) state_nxt = RUN;
            end
            RUN: begin
                if (done_cond) begin
                    uop_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            uop_q        <= '0;
            nrem         <= '0;
            wrem         <= '0;
            uop_sent     <= 1'b0;
            naddr        <= '0;
            waddr        <= '0;
            n_inflight   <= 1'b0;
            w_inflight   <= 1'b0;
            err_zero_uop <= 1'b0;
        end else begin
            state      <= state_nxt;
            n_inflight <= n_issue;
            w_inflight <= w_issue;
            if (uop_accept) begin
                uop_q    <= ib_ctl_uop;
                nrem     <= ib_ctl_uop;
                wrem     <= ib_ctl_uop;
                uop_sent <= 1'b0;
                if (ib_ctl_uop == '0) err_zero_uop <= 1'b1;
            end else if (uop_handoff) begin
                uop_sent <= 1'b1;
            end
            // Address counters run across uops and wrap silently.
            if (n_issue) begin
                nrem  <= nrem - UOP_W'(1);
                naddr <= naddr + ADDR_W'(1);
            end
            if (w_issue) begin
                wrem  <= wrem - UOP_W'(1);
                waddr <= waddr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mpe_fetch_ctrl.sv
// Bench for mpe_fetch_ctrl: transaction-level model of addresses, beats and
// completion checked every cycle, plus directed literal expectations.
module tb_mpe_fetch_ctrl;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 16;
    localparam int UOP_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [UOP_W-1:0]  ib_ctl_uop = '0;
    logic              ib_ctl_uop_valid = 1'b0;
    logic              ib_ctl_uop_ready;
    logic              nram_rd_en;
    logic [ADDR_W-1:0] nram_rd_addr;
    logic [DATA_W-1:0] nram_rd_data = '1;
    logic              wram_rd_en;
    logic [ADDR_W-1:0] wram_rd_addr;
    logic [DATA_W-1:0] wram_rd_data = '1;
    logic [UOP_W-1:0]  mpe_uop;
    logic              mpe_uop_valid;
    logic              mpe_uop_ready = 1'b1;
    logic [DATA_W-1:0] mpe_neuron;
    logic              mpe_neuron_valid;
    logic              mpe_neuron_ready = 1'b1;
    logic [DATA_W-1:0] mpe_weight;
    logic              mpe_weight_valid;
    logic              mpe_weight_ready = 1'b1;
    logic              busy;
    logic              uop_done;
    logic              err_zero_uop;

    always #5 clk = ~clk;

    mpe_fetch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .UOP_W(UOP_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ib_ctl_uop       (ib_ctl_uop),
        .ib_ctl_uop_valid (ib_ctl_uop_valid),
        .ib_ctl_uop_ready (ib_ctl_uop_ready),
        .nram_rd_en       (nram_rd_en),
        .nram_rd_addr     (nram_rd_addr),
        .nram_rd_data     (nram_rd_data),
        .wram_rd_en       (wram_rd_en),
        .wram_rd_addr     (wram_rd_addr),
        .wram_rd_data     (wram_rd_data),
        .mpe_uop          (mpe_uop),
        .mpe_uop_valid    (mpe_uop_valid),
        .mpe_uop_ready    (mpe_uop_ready),
        .mpe_neuron       (mpe_neuron),
        .mpe_neuron_valid (mpe_neuron_valid),
        .mpe_neuron_ready (mpe_neuron_ready),
        .mpe_weight       (mpe_weight),
        .mpe_weight_valid (mpe_weight_valid),
        .mpe_weight_ready (mpe_weight_ready),
        .busy             (busy),
        .uop_done         (uop_done),
        .err_zero_uop     (err_zero_uop)
    );

    function automatic logic [DATA_W-1:0] nword(input logic [15:0] a);
        return {16{a, ~a}};
    endfunction

    function automatic logic [DATA_W-1:0] wword(input logic [15:0] a);
        return {16{a ^ 16'h5A5A, a}};
    endfunction

    // One-cycle-latency memories; idle cycles return a pattern no address produces.
    always @(posedge clk) begin
        nram_rd_data <= nram_rd_en ? nword(nram_rd_addr) : {DATA_W{1'b1}};
        wram_rd_data <= wram_rd_en ? wword(wram_rd_addr) : {DATA_W{1'b1}};
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got ..%016h expected ..%016h", nm, act[63:0], exp[63:0]);
        end
    endtask

    // Ready modes: 0 always ready, 1 random, 2 held low.
    int n_mode = 0;
    int w_mode = 0;
    int u_mode = 0;

    function automatic logic rdy(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        #1;
        mpe_neuron_ready = rdy(n_mode);
        mpe_weight_ready = rdy(w_mode);
        mpe_uop_ready    = rdy(u_mode);
    end

    // Reference model state
    int          cyc = 0;
    logic [15:0] n_exp, w_exp;
    logic [15:0] nq[$], wq[$];
    logic [15:0] n_log[$], w_log[$];
    bit          in_uop, sent_m, err_m, exp_done;
    int          cur_uop, cur_n_iss, cur_w_iss, cur_n_pops, cur_w_pops;
    int          n_iss = 0, w_iss = 0, n_pops = 0, w_pops = 0, done_cnt = 0;
    int          acc_cyc, mpe_acc_cyc, done_cyc, n_first, n_last, w_first;
    bit          n_stall, w_stall, u_stall;
    logic [DATA_W-1:0] n_prev, w_prev;
    logic [UOP_W-1:0]  u_prev;
    logic [15:0]       a;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            nq.delete(); wq.delete();
            n_exp = 0; w_exp = 0;
            in_uop = 0; sent_m = 0; err_m = 0;
            n_stall = 0; w_stall = 0; u_stall = 0;
            cur_n_pops = 0; cur_w_pops = 0; cur_n_iss = 0; cur_w_iss = 0;
        end else begin
            exp_done = in_uop && sent_m && cur_n_pops == cur_uop && cur_w_pops == cur_uop;
            chk("uop_done", uop_done, exp_done);
            chk("busy", busy, in_uop);
            chk("ib_ready", ib_ctl_uop_ready, !in_uop);
            chk("err_zero_uop", err_zero_uop, err_m);
            chk("mpe_uop_valid", mpe_uop_valid, in_uop && !sent_m);

            if (u_stall) begin
                chk("mpe_uop_hold_valid", mpe_uop_valid, 1);
                chk("mpe_uop_hold", mpe_uop, u_prev);
            end
            if (mpe_uop_valid && mpe_uop_ready) begin
                chk("mpe_uop", mpe_uop, cur_uop);
                sent_m = 1;
                mpe_acc_cyc = cyc;
            end
            u_stall = mpe_uop_valid && !mpe_uop_ready;
            u_prev  = mpe_uop;

            if (n_stall) begin
                chk("neuron_hold_valid", mpe_neuron_valid, 1);
                chkd("neuron_hold", mpe_neuron, n_prev);
            end
            if (mpe_neuron_valid && mpe_neuron_ready) begin
                if (nq.size() == 0) chk("neuron_extra_beat", 1, 0);
                else begin
                    a = nq.pop_front();
                    chkd("neuron_data", mpe_neuron, nword(a));
                end
                cur_n_pops++; n_pops++;
            end
            n_stall = mpe_neuron_valid && !mpe_neuron_ready;
            n_prev  = mpe_neuron;

            if (w_stall) begin
                chk("weight_hold_valid", mpe_weight_valid, 1);
                chkd("weight_hold", mpe_weight, w_prev);
            end
            if (mpe_weight_valid && mpe_weight_ready) begin
                if (wq.size() == 0) chk("weight_extra_beat", 1, 0);
                else begin
                    a = wq.pop_front();
                    chkd("weight_data", mpe_weight, wword(a));
                end
                cur_w_pops++; w_pops++;
            end
            w_stall = mpe_weight_valid && !mpe_weight_ready;
            w_prev  = mpe_weight;

            if (nram_rd_en) begin
                chk("nram_addr", nram_rd_addr, n_exp);
                chk("nram_rd_legal", in_uop && cur_n_iss < cur_uop, 1);
                nq.push_back(n_exp);
                n_log.push_back(nram_rd_addr);
                if (cur_n_iss == 0) n_first = cyc;
                n_last = cyc;
                n_exp++; cur_n_iss++; n_iss++;
                chk("nram_outstanding", nq.size() <= 2, 1);
            end
            if (wram_rd_en) begin
                chk("wram_addr", wram_rd_addr, w_exp);
                chk("wram_rd_legal", in_uop && cur_w_iss < cur_uop, 1);
                wq.push_back(w_exp);
                w_log.push_back(wram_rd_addr);
                if (cur_w_iss == 0) w_first = cyc;
                w_exp++; cur_w_iss++; w_iss++;
                chk("wram_outstanding", wq.size() <= 2, 1);
            end

            if (uop_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (exp_done) in_uop = 0;
            if (ib_ctl_uop_valid && ib_ctl_uop_ready) begin
                cur_uop = int'(ib_ctl_uop);
                in_uop = 1; sent_m = 0;
                cur_n_iss = 0; cur_w_iss = 0; cur_n_pops = 0; cur_w_pops = 0;
                if (ib_ctl_uop == 0) err_m = 1;
                acc_cyc = cyc;
                n_log.delete(); w_log.delete();
            end
        end
    end

    task automatic send_uop(input logic [7:0] v, input bit rnd);
        bit ok = 0;
        if (rnd) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        ib_ctl_uop = v;
        ib_ctl_uop_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (ib_ctl_uop_ready) begin
                ok = 1;
                @(posedge clk); #1;
            end
        end
        ib_ctl_uop_valid = 1'b0;
        ib_ctl_uop = 8'($urandom);
        chk("uop_accept_timeout", ok, 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_cnt >= target) ok = 1;
        end
        chk("uop_done_timeout", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base_done, base_n, base_w, base_np, base_wp, rem, b;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ib_ready", ib_ctl_uop_ready, 1);
        chk("rst_uop_valid", mpe_uop_valid, 0);
        chk("rst_neuron_valid", mpe_neuron_valid, 0);
        chk("rst_weight_valid", mpe_weight_valid, 0);
        chk("rst_rd_en", {nram_rd_en, wram_rd_en}, 0);
        chk("rst_addr", {nram_rd_addr, wram_rd_addr}, 0);
        chk("rst_err", err_zero_uop, 0);
        @(posedge clk); #1;

        // Single uop of 5, PE always ready
        base_done = done_cnt; base_np = n_pops; base_wp = w_pops;
        send_uop(8'h05, 0);
        wait_done(base_done + 1, 200);
        chk("t1_mpe_uop_cycle", mpe_acc_cyc - acc_cyc, 1);
        chk("t1_first_nrd", n_first - acc_cyc, 1);
        chk("t1_first_wrd", w_first - acc_cyc, 1);
        chk("t1_nrd_span", n_last - n_first, 4);
        chk("t1_n_reads", n_log.size(), 5);
        chk("t1_naddr0", n_log[0], 16'h0000);
        chk("t1_naddr4", n_log[4], 16'h0004);
        chk("t1_waddr4", w_log[4], 16'h0004);
        chk("t1_n_beats", n_pops - base_np, 5);
        chk("t1_w_beats", w_pops - base_wp, 5);
        chk("t1_done_count", done_cnt - base_done, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("t1_busy_after", busy, 0);

        // Four uops of 35 with random handshakes everywhere
        do_reset();
        n_mode = 1; w_mode = 1; u_mode = 1;
        base_done = done_cnt; base_np = n_pops; base_wp = w_pops;
        for (int k = 0; k < 4; k++) send_uop(8'h23, 1);
        wait_done(base_done + 4, 3000);
        chk("t2_done_count", done_cnt - base_done, 4);
        chk("t2_n_beats", n_pops - base_np, 140);
        chk("t2_w_beats", w_pops - base_wp, 140);
        chk("t2_last_naddr", n_log[34], 16'd139);
        n_mode = 0; w_mode = 0; u_mode = 0;
        @(posedge clk); #1;

        // Neuron stream stalled for 20 cycles, weight stream free-running
        base_done = done_cnt; base_n = n_iss; base_w = w_iss; base_np = n_pops;
        n_mode = 2;
        send_uop(8'h08, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_n_reads_stalled", n_iss - base_n, 2);
        chk("t3_w_reads_stalled", w_iss - base_w, 8);
        n_mode = 0;
        wait_done(base_done + 1, 200);
        chk("t3_n_beats", n_pops - base_np, 8);

        // Zero-count uop
        base_done = done_cnt; base_n = n_iss; base_w = w_iss;
        send_uop(8'h00, 0);
        wait_done(base_done + 1, 100);
        chk("t4_done_after_handoff", done_cyc - mpe_acc_cyc, 1);
        chk("t4_no_nreads", n_iss - base_n, 0);
        chk("t4_no_wreads", w_iss - base_w, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_err_sticky", err_zero_uop, 1);

        // Reset in the middle of a uop
        base_done = done_cnt;
        send_uop(8'h05, 0);
        for (int i = 0; i < 50 && cur_n_iss < 2; i++) @(negedge clk);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("t6_uop_valid", mpe_uop_valid, 0);
        chk("t6_neuron_valid", mpe_neuron_valid, 0);
        chk("t6_weight_valid", mpe_weight_valid, 0);
        chk("t6_addr", {nram_rd_addr, wram_rd_addr}, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ib_ready", ib_ctl_uop_ready, 1);
        chk("t6_err_cleared", err_zero_uop, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt - base_done, 0);
        send_uop(8'h02, 0);
        wait_done(base_done + 1, 100);
        chk("t6_naddr0", n_log[0], 16'h0000);
        chk("t6_naddr1", n_log[1], 16'h0001);
        chk("t6_waddr1", w_log[1], 16'h0001);

        // Walk the address counters up to the wrap point
        rem = 16'hFFFE - int'(n_exp);
        while (rem > 0) begin
            b = (rem > 255) ? 255 : rem;
            base_done = done_cnt;
            send_uop(8'(b), 0);
            wait_done(base_done + 1, 1000);
            rem -= b;
        end
        base_done = done_cnt;
        send_uop(8'h04, 0);
        wait_done(base_done + 1, 100);
        chk("t5_naddr0", n_log[0], 16'hFFFE);
        chk("t5_naddr1", n_log[1], 16'hFFFF);
        chk("t5_naddr2", n_log[2], 16'h0000);
        chk("t5_naddr3", n_log[3], 16'h0001);
        chk("t5_waddr2", w_log[2], 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
